// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the multicore RAM port arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one RAM port among CPUS cores (dcache over icache within a core).
// Optional per-core completion counters (grant_cnt) are enabled by defining MEM_BUS_ARB_STATS_EN.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int CPUS  = 2,
    parameter int PTR_W = (CPUS > 1) ? $clog2(CPUS) : 1
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [CPUS-1:0]       iREN,
    input  logic [CPUS-1:0]       dREN,
    input  logic [CPUS-1:0]       dWEN,
    input  logic [CPUS-1:0][31:0] iaddr,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    output logic [CPUS-1:0]       iwait,
    output logic [CPUS-1:0]       dwait,
    output logic [CPUS-1:0][31:0] iload,
    output logic [CPUS-1:0][31:0] dload,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  ramstate_t             ramstate
`ifdef MEM_BUS_ARB_STATS_EN
    ,
    output logic [CPUS-1:0][15:0] grant_cnt
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IREN = 2'd1,
        SRC_DREN = 2'd2,
        SRC_DWEN = 2'd3
    } src_t;

    state_t           state, state_d;
    src_t             src, src_d, win_src;
    logic [PTR_W-1:0] rr_ptr, rr_ptr_d, owner, owner_d, win_core;
    logic             found;
    logic             req_held;
    logic             done;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of process ordering.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            src    <= SRC_NONE;
        end else begin
            state  <= state_d;
            rr_ptr <= rr_ptr_d;
            owner  <= owner_d;
            src    <= src_d;
        end
    end

    // Scan cores starting at rr_ptr; the first core with any request wins.
    always_comb begin
        found    = 1'b0;
        win_core = '0;
        win_src  = SRC_NONE;
        for (int i = 0; i < CPUS; i++) begin
            int k;
            k = int'(rr_ptr) + i;
            if (k >= CPUS) k = k - CPUS;
            if (!found && (iREN[k] || dREN[k] || dWEN[k])) begin
                found    = 1'b1;
                win_core = PTR_W'(k);
                if (dWEN[k])      win_src = SRC_DWEN;
                else if (dREN[k]) win_src = SRC_DREN;
                else              win_src = SRC_IREN;
            end
        end
    end

    always_comb begin
        case (src)
            SRC_DWEN: req_held = dWEN[owner];
            SRC_DREN: req_held = dREN[owner];
            SRC_IREN: req_held = iREN[owner];
            default:  req_held = 1'b0;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d  = state;
        rr_ptr_d = rr_ptr;
        owner_d  = owner;
        src_d    = src;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = '1;
        dwait    = '1;
        done     = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    owner_d = win_core;
                    src_d   = win_src;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                case (src)
                    SRC_DWEN: begin
                        ramWEN   = 1'b1;
                        ramaddr  = daddr[owner];
                        ramstore = dstore[owner];
                    end
                    SRC_DREN: begin
                        ramREN  = 1'b1;
                        ramaddr = daddr[owner];
                    end
                    SRC_IREN: begin
                        ramREN  = 1'b1;
                        ramaddr = iaddr[owner];
                    end
                    default: ;
                endcase

                // A dropped request aborts without a wait pulse or pointer advance.
                if (!req_held) begin
                    state_d = IDLE;
                end else if (ramstate == ACCESS) begin
                    done = 1'b1;
                    if (src == SRC_IREN) iwait[owner] = 1'b0;
                    else                 dwait[owner] = 1'b0;
                    rr_ptr_d = (owner == PTR_W'(CPUS - 1)) ? '0 : owner + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign iload = {CPUS{ramload}};
    assign dload = {CPUS{ramload}};

`ifdef MEM_BUS_ARB_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            grant_cnt <= '0;
        end else begin
            for (int c = 0; c < CPUS; c++) begin
                if (done && owner == PTR_W'(c) && grant_cnt[c] != 16'hFFFF)
                    grant_cnt[c] <= grant_cnt[c] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: cycle-by-cycle vector table plus directed multi-cycle sequences.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int CPUS = 2;

    logic                  CLK = 1'b0;
    logic                  nRST;
    logic [CPUS-1:0]       iREN, dREN, dWEN;
    logic [CPUS-1:0][31:0] iaddr, daddr, dstore;
    logic [CPUS-1:0]       iwait, dwait;
    logic [CPUS-1:0][31:0] iload, dload;
    logic                  ramREN, ramWEN;
    logic [31:0]           ramaddr, ramstore, ramload;
    ramstate_t             ramstate;
`ifdef MEM_BUS_ARB_STATS_EN
    logic [CPUS-1:0][15:0] grant_cnt;
`endif

    mem_bus_arbiter #(.CPUS(CPUS)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .iaddr    (iaddr),
        .daddr    (daddr),
        .dstore   (dstore),
        .iwait    (iwait),
        .dwait    (dwait),
        .iload    (iload),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
`ifdef MEM_BUS_ARB_STATS_EN
        ,
        .grant_cnt(grant_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  i, r, w;
        ramstate_t   rs;
        logic        chk;
        logic        ren, wen;
        logic [31:0] addr, store;
        logic [1:0]  iw, dw;
    } vec_t;

    function automatic vec_t v(input logic [1:0] i, input logic [1:0] r, input logic [1:0] w,
                               input ramstate_t rs, input logic chk, input logic ren,
                               input logic wen, input logic [31:0] addr, input logic [31:0] store,
                               input logic [1:0] iw, input logic [1:0] dw);
        vec_t t;
        t.i = i; t.r = r; t.w = w; t.rs = rs; t.chk = chk; t.ren = ren; t.wen = wen;
        t.addr = addr; t.store = store; t.iw = iw; t.dw = dw;
        return t;
    endfunction

    localparam int NV = 27;
    vec_t vecs [NV];

    logic [31:0] last_load;

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic [1:0] i, input logic [1:0] r, input logic [1:0] w,
                         input ramstate_t rs);
        @(negedge CLK);
        iREN     = i;
        dREN     = r;
        dWEN     = w;
        ramstate = rs;
        last_load = $urandom;
        ramload  = last_load;
        #1;
    endtask

    task automatic do_reset();
        iREN = '0; dREN = '0; dWEN = '0; ramstate = FREE;
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    int grants [$];
    int cnt0, cnt1, zeros, rem0, rem1;

    initial begin
        iaddr[0]  = 32'h0000_1000; iaddr[1]  = 32'h0000_0100;
        daddr[0]  = 32'h0000_0004; daddr[1]  = 32'h0000_0200;
        dstore[0] = 32'h1111_1111; dstore[1] = 32'hDEAD_BEEF;
        ramload   = '0;
        last_load = '0;

        // Reset held with every request high.
        nRST = 1'b0; iREN = '1; dREN = '1; dWEN = '1; ramstate = FREE;
        repeat (2) @(negedge CLK);
        #1;
        check("rst ramREN", 32'(ramREN), 32'd0);
        check("rst ramWEN", 32'(ramWEN), 32'd0);
        check("rst ramaddr", ramaddr, 32'd0);
        check("rst ramstore", ramstore, 32'd0);
        check("rst iwait", 32'(iwait), 32'd3);
        check("rst dwait", 32'(dwait), 32'd3);
        nRST = 1'b1;
        check("rel idle ramWEN", 32'(ramWEN), 32'd0);
        @(negedge CLK); #1;
        check("rel grant ramWEN", 32'(ramWEN), 32'd1);
        check("rel grant ramaddr", ramaddr, 32'h04);
        check("rel grant ramstore", ramstore, 32'h1111_1111);
        do_reset();

        vecs[0]  = v(2'b00, 2'b00, 2'b00, FREE,   1, 0, 0, 32'h0,   32'h0,          2'b11, 2'b11);
        vecs[1]  = v(2'b10, 2'b00, 2'b10, FREE,   1, 0, 0, 32'h0,   32'h0,          2'b11, 2'b11);
        vecs[2]  = v(2'b10, 2'b00, 2'b10, BUSY,   1, 0, 1, 32'h200, 32'hDEAD_BEEF,  2'b11, 2'b11);
        vecs[3]  = v(2'b10, 2'b00, 2'b10, ACCESS, 1, 0, 1, 32'h200, 32'hDEAD_BEEF,  2'b11, 2'b01);
        vecs[4]  = v(2'b10, 2'b00, 2'b00, FREE,   1, 0, 0, 32'h0,   32'h0,          2'b11, 2'b11);
        vecs[5]  = v(2'b10, 2'b00, 2'b00, BUSY,   1, 1, 0, 32'h100, 32'h0,          2'b11, 2'b11);
        vecs[6]  = v(2'b10, 2'b00, 2'b00, ACCESS, 1, 1, 0, 32'h100, 32'h0,          2'b01, 2'b11);
        vecs[7]  = v(2'b00, 2'b11, 2'b00, FREE,   1, 0, 0, 32'h0,   32'h0,          2'b11, 2'b11);
        vecs[8]  = v(2'b00, 2'b11, 2'b00, ACCESS, 1, 1, 0, 32'h04,  32'h0,          2'b11, 2'b10);
        vecs[9]  = v(2'b00, 2'b11, 2'b00, FREE,   1, 0, 0, 32'h0,   32'h0,          2'b11, 2'b11);
        vecs[10] = v(2'b00, 2'b11, 2'b00, ACCESS, 1, 1, 0, 32'h200, 32'h0,          2'b11, 2'b01);
        vecs[11] = v(2'b00, 2'b11, 2'b00, FREE,   1, 0, 0, 32'h0,   32'h0,          2'b11, 2'b11);
        vecs[12] = v(2'b00, 2'b11, 2'b00, ERROR,  1, 1, 0, 32'h04,  32'h0,          2'b11, 2'b11);
        vecs[13] = v(2'b00, 2'b11, 2'b00, ACCESS, 1, 1, 0, 32'h04,  32'h0,          2'b11, 2'b10);
        vecs[14] = v(2'b00, 2'b11, 2'b00, FREE,   1, 0, 0, 32'h0,   32'h0,          2'b11, 2'b11);
        vecs[15] = v(2'b00, 2'b11, 2'b00, ACCESS, 1, 1, 0, 32'h200, 32'h0,          2'b11, 2'b01);
        vecs[16] = v(2'b00, 2'b01, 2'b00, FREE,   1, 0, 0, 32'h0,   32'h0,          2'b11, 2'b11);
        vecs[17] = v(2'b00, 2'b01, 2'b01, ACCESS, 1, 1, 0, 32'h04,  32'h0,          2'b11, 2'b10);
        vecs[18] = v(2'b00, 2'b00, 2'b00, FREE,   1, 0, 0, 32'h0,   32'h0,          2'b11, 2'b11);
        vecs[19] = v(2'b00, 2'b10, 2'b00, FREE,   1, 0, 0, 32'h0,   32'h0,          2'b11, 2'b11);
        vecs[20] = v(2'b00, 2'b10, 2'b00, ACCESS, 1, 1, 0, 32'h200, 32'h0,          2'b11, 2'b01);
        vecs[21] = v(2'b00, 2'b01, 2'b00, FREE,   1, 0, 0, 32'h0,   32'h0,          2'b11, 2'b11);
        vecs[22] = v(2'b00, 2'b01, 2'b00, BUSY,   1, 1, 0, 32'h04,  32'h0,          2'b11, 2'b11);
        vecs[23] = v(2'b00, 2'b10, 2'b00, BUSY,   0, 0, 0, 32'h0,   32'h0,          2'b11, 2'b11);
        vecs[24] = v(2'b00, 2'b11, 2'b00, FREE,   1, 0, 0, 32'h0,   32'h0,          2'b11, 2'b11);
        vecs[25] = v(2'b00, 2'b11, 2'b00, ACCESS, 1, 1, 0, 32'h04,  32'h0,          2'b11, 2'b10);
        vecs[26] = v(2'b00, 2'b00, 2'b00, FREE,   1, 0, 0, 32'h0,   32'h0,          2'b11, 2'b11);

        for (int n = 0; n < NV; n++) begin
            drive(vecs[n].i, vecs[n].r, vecs[n].w, vecs[n].rs);
            if (vecs[n].chk) begin
                check($sformatf("v%0d ramREN", n), 32'(ramREN), 32'(vecs[n].ren));
                check($sformatf("v%0d ramWEN", n), 32'(ramWEN), 32'(vecs[n].wen));
                if (vecs[n].ren || vecs[n].wen)
                    check($sformatf("v%0d ramaddr", n), ramaddr, vecs[n].addr);
                if (vecs[n].wen)
                    check($sformatf("v%0d ramstore", n), ramstore, vecs[n].store);
            end
            check($sformatf("v%0d iwait", n), 32'(iwait), 32'(vecs[n].iw));
            check($sformatf("v%0d dwait", n), 32'(dwait), 32'(vecs[n].dw));
        end

        // Single core0 read with a 10-cycle RAM latency.
        do_reset();
        zeros = 0;
        drive(2'b00, 2'b01, 2'b00, BUSY);
        check("lat idle ramREN", 32'(ramREN), 32'd0);
        for (int k = 0; k < 10; k++) begin
            drive(2'b00, 2'b01, 2'b00, (k == 9) ? ACCESS : BUSY);
            check($sformatf("lat%0d ramREN", k), 32'(ramREN), 32'd1);
            check($sformatf("lat%0d ramaddr", k), ramaddr, 32'h04);
            check($sformatf("lat%0d dwait", k), 32'(dwait), (k == 9) ? 32'd2 : 32'd3);
            if (dwait[0] == 1'b0) zeros++;
            if (k == 9) begin
                check("lat dload0", dload[0], last_load);
                check("lat dload1", dload[1], last_load);
                check("lat iload0", iload[0], last_load);
            end
        end
        drive(2'b00, 2'b00, 2'b00, FREE);
        if (dwait[0] == 1'b0) zeros++;
        check("lat dwait0 pulses", 32'(zeros), 32'd1);
        check("lat after ramREN", 32'(ramREN), 32'd0);

        // Both cores hold dREN with an always-ready RAM.
        do_reset();
        grants.delete();
        for (int c = 0; c < 16 && grants.size() < 4; c++) begin
            drive(2'b00, 2'b11, 2'b00, ACCESS);
            check($sformatf("rr c%0d single owner", c), 32'(dwait[0] | dwait[1]), 32'd1);
            if (!dwait[0]) grants.push_back(0);
            if (!dwait[1]) grants.push_back(1);
        end
        check("rr grant count", 32'(grants.size()), 32'd4);
        cnt0 = 0; cnt1 = 0;
        for (int g = 0; g < grants.size() && g < 4; g++) begin
            check($sformatf("rr order %0d", g), 32'(grants[g]), 32'(g % 2));
            if (grants[g] == 0) cnt0++; else cnt1++;
        end
        check("rr core0 completions", 32'(cnt0), 32'd2);
        check("rr core1 completions", 32'(cnt1), 32'd2);

`ifdef MEM_BUS_ARB_STATS_EN
        // Three core0 reads and two core1 reads.
        do_reset();
        rem0 = 3; rem1 = 2;
        for (int c = 0; c < 30 && (rem0 + rem1) > 0; c++) begin
            drive(2'b00, {rem1 > 0, rem0 > 0}, 2'b00, ACCESS);
            if (!dwait[0]) rem0--;
            if (!dwait[1]) rem1--;
        end
        check("stats remaining", 32'(rem0 + rem1), 32'd0);
        drive(2'b00, 2'b00, 2'b00, FREE);
        check("stats grant_cnt", grant_cnt, {16'd2, 16'd3});
`endif

        // Asynchronous reset in the middle of a write grant.
        do_reset();
        drive(2'b00, 2'b00, 2'b10, BUSY);
        drive(2'b00, 2'b00, 2'b10, BUSY);
        check("mid ramWEN before", 32'(ramWEN), 32'd1);
        check("mid ramaddr before", ramaddr, 32'h200);
        check("mid ramstore before", ramstore, 32'hDEAD_BEEF);
        #2;
        nRST = 1'b0;
        #1;
        check("mid ramWEN async", 32'(ramWEN), 32'd0);
        check("mid dwait async", 32'(dwait), 32'd3);
        check("mid ramaddr async", ramaddr, 32'd0);
        @(negedge CLK);
        dWEN = '0;
        nRST = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
